// File: rtl/sparse_hls_deadlock_report_ctrl.sv
// Central deadlock report controller for the sparse dataflow region.
// Debounces the per-process detect flags and round-robin selects one
// originating process. It launches that process's report token, follows the
// token around the dependency cycle and then holds a frozen report until it
// is acknowledged.
module sparse_hls_deadlock_report_ctrl #(
  parameter int PROC_NUM       = 4,
  parameter int CONFIRM_CYCLES = 4,
  parameter int TIMEOUT        = 64,
  localparam int ID_W  = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1,
  localparam int HOP_W = $clog2(PROC_NUM + 1),
  localparam int TO_W  = $clog2(TIMEOUT + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_ret_vec,
  input  logic                ack,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic [PROC_NUM-1:0] token_clear_vec,
  output logic                dl_detect_global,
  output logic                report_valid,
  output logic [ID_W-1:0]     report_proc,
  output logic [PROC_NUM-1:0] report_mask,
  output logic [HOP_W-1:0]    report_hops,
  output logic                report_timeout
);

  localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIRM,
    S_ORIGIN,
    S_WALK,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ID_W-1:0]     r_sel;
  logic [ID_W-1:0]     r_rr;
  logic [CNT_W-1:0]    r_cnt;
  logic [TO_W-1:0]     r_walk;
  logic [PROC_NUM-1:0] r_mask;
  logic [HOP_W-1:0]    r_hops;
  logic                r_to;
  logic [ID_W-1:0]     r_proc;

  logic [ID_W-1:0]     w_pick;
  logic [PROC_NUM-1:0] w_sel_oh;
  logic                w_det_sel;
  logic                w_ret_sel;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [TO_W-1:0]     w_walk_inc;

  // First requesting process at or above the round-robin pointer, wrapping.
  function automatic logic [ID_W-1:0] f_pick(input logic [PROC_NUM-1:0] vec,
                                             input logic [ID_W-1:0]     rr);
    logic [ID_W-1:0]     res;
    logic                found;
    logic [PROC_NUM-1:0] sh;
    int                  idx;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < PROC_NUM; i++) begin
      idx = int'(rr) + i;
      if (idx >= PROC_NUM) idx = idx - PROC_NUM;
      sh = vec >> idx;
      if (!found && sh[0]) begin
        found = 1'b1;
        res   = ID_W'(idx);
      end
    end
    return res;
  endfunction

  assign w_pick     = f_pick(dl_detect_vec, r_rr);
  assign w_sel_oh   = PROC_NUM'(1) << r_sel;
  assign w_det_sel  = |(dl_detect_vec & w_sel_oh);
  assign w_ret_sel  = |(token_ret_vec & w_sel_oh);
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_walk_inc = r_walk + TO_W'(1);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (|dl_detect_vec) w_next = S_CONFIRM;
      S_CONFIRM: begin
        if (!w_det_sel)                                w_next = S_IDLE;
        else if (w_cnt_inc == CNT_W'(CONFIRM_CYCLES)) w_next = S_ORIGIN;
      end
      S_ORIGIN:  w_next = S_WALK;
      S_WALK:    if (w_ret_sel || (w_walk_inc == TO_W'(TIMEOUT))) w_next = S_DONE;
      S_DONE:    if (ack) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Selection, debounce count, walk bookkeeping and the held report fields.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sel  <= '0;
      r_rr   <= '0;
      r_cnt  <= '0;
      r_walk <= '0;
      r_mask <= '0;
      r_hops <= '0;
      r_to   <= 1'b0;
      r_proc <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|dl_detect_vec) begin
            r_sel <= w_pick;
            r_cnt <= CNT_W'(1);
          end
        end
        S_CONFIRM: begin
          if (w_det_sel) r_cnt <= w_cnt_inc;
        end
        S_ORIGIN: begin
          r_mask <= '0;
          r_hops <= '0;
          r_walk <= '0;
          r_to   <= 1'b0;
          r_proc <= r_sel;
        end
        S_WALK: begin
          r_mask <= r_mask | token_ret_vec;
          if ((|token_ret_vec) && (r_hops != {HOP_W{1'b1}})) r_hops <= r_hops + HOP_W'(1);
          r_walk <= w_walk_inc;
          // A token return in the final timeout cycle still counts as a return.
          if (!w_ret_sel && (w_walk_inc == TO_W'(TIMEOUT))) r_to <= 1'b1;
        end
        S_DONE: begin
          if (ack) r_rr <= (r_sel == ID_W'(PROC_NUM - 1)) ? '0 : r_sel + ID_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign origin_vec       = (r_state == S_ORIGIN) ? w_sel_oh : '0;
  assign token_clear_vec  = ((r_state == S_WALK) && w_ret_sel) ? w_sel_oh : '0;
  assign dl_detect_global = (r_state == S_ORIGIN) || (r_state == S_WALK) || (r_state == S_DONE);
  assign report_valid     = (r_state == S_DONE);
  assign report_proc      = r_proc;
  assign report_mask      = r_mask;
  assign report_hops      = r_hops;
  assign report_timeout   = r_to;

endmodule

// File: tb/tb_sparse_hls_deadlock_report_ctrl.sv
// Bench for sparse_hls_deadlock_report_ctrl: directed scenarios followed by
// randomized traffic, compared every cycle against a reference model.
module tb_sparse_hls_deadlock_report_ctrl;

  localparam int N    = 4;
  localparam int CONF = 4;
  localparam int TMO  = 8;
  localparam int HMAX = 7;

  logic         clock;
  logic         reset;
  logic [N-1:0] dl;
  logic [N-1:0] tok;
  logic         ack;
  logic [N-1:0] origin_vec;
  logic [N-1:0] token_clear_vec;
  logic         dl_detect_global;
  logic         report_valid;
  logic [1:0]   report_proc;
  logic [N-1:0] report_mask;
  logic [2:0]   report_hops;
  logic         report_timeout;

  int n_chk;
  int n_err;

  // Reference model: phase 0 idle, 1 confirm, 2 origin, 3 walk, 4 done.
  int m_phase, m_sel, m_rr, m_cnt, m_walk, m_mask, m_hops, m_to, m_proc;

  sparse_hls_deadlock_report_ctrl #(
    .PROC_NUM(N), .CONFIRM_CYCLES(CONF), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset), .dl_detect_vec(dl), .token_ret_vec(tok), .ack(ack),
    .origin_vec(origin_vec), .token_clear_vec(token_clear_vec),
    .dl_detect_global(dl_detect_global), .report_valid(report_valid),
    .report_proc(report_proc), .report_mask(report_mask),
    .report_hops(report_hops), .report_timeout(report_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit bit_of(input int v, input int p);
    return ((v >> p) & 1) != 0;
  endfunction

  function automatic int pick(input int v, input int rr);
    for (int k = 0; k < N; k++) if (bit_of(v, (rr + k) % N)) return (rr + k) % N;
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_sel = 0; m_rr = 0; m_cnt = 0; m_walk = 0;
    m_mask = 0; m_hops = 0; m_to = 0; m_proc = 0;
  endtask

  task automatic model_step();
    int v, t;
    v = 32'(dl);
    t = 32'(tok);
    if (reset) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: if (v != 0) begin m_sel = pick(v, m_rr); m_cnt = 1; m_phase = 1; end
      1: begin
        if (!bit_of(v, m_sel)) m_phase = 0;
        else begin
          m_cnt++;
          if (m_cnt == CONF) m_phase = 2;
        end
      end
      2: begin m_mask = 0; m_hops = 0; m_walk = 0; m_to = 0; m_proc = m_sel; m_phase = 3; end
      3: begin
        m_mask |= t;
        if (t != 0 && m_hops < HMAX) m_hops++;
        m_walk++;
        if (bit_of(t, m_sel)) begin m_to = 0; m_phase = 4; end
        else if (m_walk == TMO) begin m_to = 1; m_phase = 4; end
      end
      4: if (ack) begin m_rr = (m_sel + 1) % N; m_phase = 0; end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_outputs();
    int e_org, e_clr;
    e_org = (m_phase == 2) ? (1 << m_sel) : 0;
    e_clr = (m_phase == 3 && bit_of(32'(tok), m_sel)) ? (1 << m_sel) : 0;
    chk("origin", 32'(origin_vec), e_org);
    chk("clear", 32'(token_clear_vec), e_clr);
    chk("global", 32'(dl_detect_global), (m_phase >= 2) ? 1 : 0);
    chk("valid", 32'(report_valid), (m_phase == 4) ? 1 : 0);
    chk("proc", 32'(report_proc), m_proc);
    chk("mask", 32'(report_mask), m_mask);
    chk("hops", 32'(report_hops), m_hops);
    chk("tmo", 32'(report_timeout), m_to);
  endtask

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic cycle();
    @(negedge clock);
    check_outputs();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_phase(input int ph, input int budget);
    int n;
    n = 0;
    while (m_phase != ph && n < budget) begin
      cycle();
      n++;
    end
    if (m_phase != ph) chk("wait_phase", m_phase, ph);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("rst_global_now", 32'(dl_detect_global), 0);
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    model_reset();
    reset = 1'b1; dl = '0; tok = '0; ack = 1'b0;
    #1;
    check_outputs();
    @(posedge clock); #1;
    cycle();
    reset = 1'b0;

    // Two reports from a held 1001 pattern: process 0 first, then 3.
    dl = 4'b1001;
    wait_phase(3, 20);
    tok = 4'b0001;
    #1;
    chk("R1_clear", 32'(token_clear_vec), 32'h1);
    cycle();
    tok = '0;
    chk("R1_proc", 32'(report_proc), 0);
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    wait_phase(3, 20);
    tok = 4'b1000;
    cycle();
    tok = '0;
    chk("R2_valid", 32'(report_valid), 1);
    chk("R2_proc", 32'(report_proc), 3);
    ack = 1'b1; dl = '0;
    cycle();
    ack = 1'b0;
    cycle(); cycle();

    // Single report from process 2 with the token visiting 1, 3, 2.
    dl = 4'b0100;
    repeat (4) cycle();
    chk("A_origin", 32'(origin_vec), 32'h4);
    chk("A_global", 32'(dl_detect_global), 1);
    cycle();
    tok = 4'b0010; cycle();
    tok = 4'b1000; cycle();
    tok = 4'b0100;
    #1;
    chk("A_clear", 32'(token_clear_vec), 32'h4);
    cycle();
    tok = '0;
    chk("A_valid", 32'(report_valid), 1);
    chk("A_proc", 32'(report_proc), 2);
    chk("A_mask", 32'(report_mask), 32'hE);
    chk("A_hops", 32'(report_hops), 3);
    chk("A_tmo", 32'(report_timeout), 0);
    ack = 1'b1; dl = '0;
    cycle();
    ack = 1'b0;
    chk("A_valid_drop", 32'(report_valid), 0);
    chk("A_global_drop", 32'(dl_detect_global), 0);
    chk("A_mask_kept", 32'(report_mask), 32'hE);
    cycle();

    // Short detect glitch never reaches ORIGIN.
    dl = 4'b0010;
    cycle(); cycle();
    dl = '0;
    repeat (8) begin
      cycle();
      chk("B_no_origin", 32'(origin_vec), 0);
      chk("B_no_valid", 32'(report_valid), 0);
    end

    // Walk with no token return ends by timeout.
    dl = 4'b0001;
    repeat (12) cycle();
    chk("T_not_yet", 32'(report_valid), 0);
    cycle();
    chk("T_valid", 32'(report_valid), 1);
    chk("T_tmo", 32'(report_timeout), 1);
    chk("T_hops", 32'(report_hops), 0);
    ack = 1'b1; dl = '0;
    cycle();
    ack = 1'b0;
    cycle();

    // Reset during WALK, detect still high: restart selects process 0.
    dl = 4'b0101;
    wait_phase(3, 20);
    cycle();
    pulse_reset();
    wait_phase(2, 20);
    chk("RS_origin", 32'(origin_vec), 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) dl = 4'($urandom_range(0, 15));
      tok = 4'($urandom & $urandom);
      if (((i >> 8) & 1) != 0) tok = tok & ~(4'b0001 << m_sel);
      ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 399) == 0) pulse_reset();
      else cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sparse_hls_deadlock_report_ctrl.md
# sparse_hls_deadlock_report_ctrl

Central controller for the per-process deadlock detect units of the sparse dataflow region. It collects the `dl_detect_out` flags from all PROC_NUM units and debounces them. It round-robin selects one reporting process, launches that process's report token (`origin`), and watches the token walk the dependency cycle. It clears the token when the token returns, then holds a frozen deadlock report until software or the testbench acknowledges it.

## Interface
Parameters:
- PROC_NUM, 4: number of processes and detect units; must be ≥ 2.
- CONFIRM_CYCLES, 4: consecutive cycles a selected detect flag must stay high before reporting starts; must be ≥ 2.
- TIMEOUT, 64: maximum WALK cycles before the walk is abandoned; must be ≥ 1.
- Derived widths: ID_W = max(1, $clog2(PROC_NUM)); HOP_W = $clog2(PROC_NUM+1); TO_W = $clog2(TIMEOUT+1).

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- dl_detect_vec  in  PROC_NUM  bit p is `dl_detect_out` of unit p.
- token_ret_vec  in  PROC_NUM  bit p is the OR-reduced `token_in_vec` of unit p; high means the token is present at p this cycle.
- ack  in  1  releases a held report; honoured only in DONE.
- origin_vec  out  PROC_NUM  one-hot `origin` per unit; a one-cycle pulse.
- token_clear_vec  out  PROC_NUM  one-hot `token_clear` per unit; combinational.
- dl_detect_global  out  1  broadcast to every unit's `dl_detect_in`.
- report_valid  out  1  a report is held.
- report_proc  out  ID_W  index of the originating process.
- report_mask  out  PROC_NUM  OR of every token_ret_vec value seen during WALK.
- report_hops  out  HOP_W  number of WALK cycles with token present; saturates at all-ones.
- report_timeout  out  1  the walk ended by timeout, not by token return.

## Operation
States: IDLE, CONFIRM, ORIGIN, WALK, DONE. Reset puts the FSM in IDLE.

Arbitration:
- Round-robin pointer `rr` (ID_W bits); reset value 0.
- Pick = first set bit of dl_detect_vec, searching upward from index rr and wrapping modulo PROC_NUM.

IDLE:
- When |dl_detect_vec: latch sel = pick, set cnt = 1, go to CONFIRM.

CONFIRM:
- If dl_detect_vec[sel] = 0: go to IDLE. sel is not preserved.
- Otherwise cnt++. When the incremented cnt equals CONFIRM_CYCLES, go to ORIGIN.
- Other bits of dl_detect_vec are ignored here.

ORIGIN (exactly one cycle):
- origin_vec = 1 << sel.
- dl_detect_global = 1.
- Clear report_mask, report_hops and the walk counter.
- Go to WALK.

WALK:
- Each cycle: report_mask |= token_ret_vec; report_hops += |token_ret_vec (saturating); walk_cnt++.
- If token_ret_vec[sel] = 1: token_clear_vec = 1 << sel in that same cycle, report_timeout = 0, go to DONE.
- Else if walk_cnt reaches TIMEOUT: report_timeout = 1, go to DONE.
- If both happen in the same cycle, the token return wins.

DONE:
- report_valid = 1; report_proc = sel; report fields are frozen.
- dl_detect_global stays 1, which freezes detection in all units.
- On ack: rr = (sel + 1) mod PROC_NUM, go to IDLE.
- report_valid and dl_detect_global drop to 0 in IDLE. The report_* data fields keep their values until the next ORIGIN clears them.

Output encoding:
- dl_detect_global = 1 in ORIGIN, WALK and DONE; 0 otherwise.
- Every output is 0 after reset.
- ack outside DONE is ignored.
- dl_detect_vec changes after CONFIRM are ignored.

## Timing
- Minimum latency from a dl_detect_vec bit rising to the origin pulse is CONFIRM_CYCLES cycles: the IDLE capture edge plus CONFIRM_CYCLES−1 CONFIRM edges, then ORIGIN.
- origin_vec, dl_detect_global and report_* are registered (decoded from state and flops).
- token_clear_vec is combinational from token_ret_vec and state. It coincides with the units' final `dl_detect_out` cycle.
- report_valid rises on the first cycle after the edge that leaves WALK.
- report_valid falls on the first cycle after the ack edge.
- Asserting reset mid-operation forces IDLE and zeroes all outputs at once, including token_clear_vec.

## Test plan
- PROC_NUM=4, CONFIRM_CYCLES=4: dl_detect_vec=4'b0100 held → origin_vec=4'b0100 for one cycle, 4 cycles after the rise; dl_detect_global=1 from that cycle.
- Same setup, then token_ret_vec visits 1, 3, 2 on successive cycles → token_clear_vec=4'b0100 in the 3rd WALK cycle; report_proc=2, report_mask=4'b1110, report_hops=3, report_timeout=0.
- dl_detect_vec=4'b0010 for 2 cycles, then 0 → FSM returns to IDLE, no origin pulse, report_valid stays 0.
- TIMEOUT=8 with no token return → DONE after 8 WALK cycles, report_timeout=1, no token_clear.
- Two reports with dl_detect_vec=4'b1001 held, ack after each → report_proc=0 first, then 3.
- Reset pulsed during WALK → all outputs 0 next cycle; dl_detect_vec still high → a new CONFIRM starts with sel=0.
